// File: rtl/uart_cmd_led_ctrl.sv
// uart_cmd_led_ctrl: parses 3-byte UART command frames {CMD, ARG, CMD} and
// drives PWM-dimmed LED channels from a hit mask ORed with an external overlay.
//
// Optional feature: define UART_CMD_ACK_EN to add a one-deep ack transmitter
// ('K' after an executed frame, 'E' after a rejected or timed-out frame).
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   rx_valid, rx_data   received byte strobe and data
//   overlay             external LED pattern ORed into the hit mask
//   led                 (hit_mask | overlay) gated by the PWM
//   hit_mask            current channel hit mask
//   brightness          current global PWM duty
//   frame_ok/frame_err  1-cycle result pulses
//   err_cnt             saturating error count
//   tx_valid/tx_data/tx_ready  ack byte handshake (UART_CMD_ACK_EN only)
module uart_cmd_led_ctrl #(
  parameter int unsigned N_CH        = 8,
  parameter int unsigned PWM_BITS    = 4,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  input  logic [N_CH-1:0]     overlay,
  output logic [N_CH-1:0]     led,
  output logic [N_CH-1:0]     hit_mask,
  output logic [PWM_BITS-1:0] brightness,
  output logic                frame_ok,
  output logic                frame_err,
  output logic [7:0]          err_cnt
`ifdef UART_CMD_ACK_EN
  ,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  input  logic                tx_ready
`endif
);

  localparam int unsigned TMR_W = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned LOW_W = (N_CH < 8) ? N_CH : 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GOT_CMD = 2'd1,
    S_GOT_ARG = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          cmd_q, cmd_d;
  logic [7:0]          arg_q, arg_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [N_CH-1:0]     mask_d;
  logic [PWM_BITS-1:0] bright_d;
  logic                ok_d, err_d;
  logic [7:0]          arg_idx;
  logic [PWM_BITS-1:0] pwm_cnt;

  // Channel index selected by an 'A' argument; values below 'A' wrap high and fall out of range
  assign arg_idx = arg_q - 8'h41;

  // Frame state register and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cmd_q      <= 8'h00;
      arg_q      <= 8'h00;
      timer_q    <= '0;
      hit_mask   <= '0;
      brightness <= '1;
      frame_ok   <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= 8'h00;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      timer_q    <= timer_d;
      hit_mask   <= mask_d;
      brightness <= bright_d;
      frame_ok   <= ok_d;
      frame_err  <= err_d;
      if (err_d && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

  // Next-state, command execution and timeout
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    arg_d    = arg_q;
    timer_d  = '0;
    mask_d   = hit_mask;
    bright_d = brightness;
    ok_d     = 1'b0;
    err_d    = 1'b0;

    if (rx_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_data inside {8'h41, 8'h42, 8'h43}) begin
            cmd_d   = rx_data;
            state_d = S_GOT_CMD;
          end else begin
            err_d = 1'b1;
          end
        end
        S_GOT_CMD: begin
          arg_d   = rx_data;
          state_d = S_GOT_ARG;
        end
        S_GOT_ARG: begin
          state_d = S_IDLE;
          if (rx_data != cmd_q) begin
            err_d = 1'b1;
          end else begin
            unique case (cmd_q)
              8'h41: begin
                if (arg_q == 8'h60) begin
                  mask_d = '0;
                  ok_d   = 1'b1;
                end else if (arg_idx < 8'(N_CH)) begin
                  for (int i = 0; i < int'(N_CH); i++) begin
                    if (arg_idx == 8'(i)) mask_d[i] = 1'b1;
                  end
                  ok_d = 1'b1;
                end else begin
                  err_d = 1'b1;
                end
              end
              8'h42: begin
                bright_d = arg_q[PWM_BITS-1:0];
                ok_d     = 1'b1;
              end
              8'h43: begin
                mask_d[LOW_W-1:0] = arg_q[LOW_W-1:0];
                ok_d              = 1'b1;
              end
              default: err_d = 1'b1;
            endcase
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      // A byte on the expiry cycle takes the branch above, so it always wins
      if (timer_q == TMR_W'(TIMEOUT_CYC)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  // Free-running PWM counter and registered LED drive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      led     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      led     <= (hit_mask | overlay) & {N_CH{pwm_cnt < brightness}};
    end
  end

`ifdef UART_CMD_ACK_EN
  // One-deep ack buffer; a new ack is accepted only when the slot is free or draining
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'h00;
    end else if ((ok_d || err_d) && (!tx_valid || tx_ready)) begin
      tx_valid <= 1'b1;
      tx_data  <= ok_d ? 8'h4B : 8'h45;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_led_ctrl.sv
// Testbench for uart_cmd_led_ctrl: directed frames, timeout, saturation,
// reset abort and randomized frames against a byte-level reference model.
module tb_uart_cmd_led_ctrl;

  localparam int unsigned N_CH     = 8;
  localparam int unsigned PWM_BITS = 4;
  localparam int unsigned TMO      = 100;

  logic                clk;
  logic                reset_n;
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic [N_CH-1:0]     overlay;
  logic [N_CH-1:0]     led;
  logic [N_CH-1:0]     hit_mask;
  logic [PWM_BITS-1:0] brightness;
  logic                frame_ok;
  logic                frame_err;
  logic [7:0]          err_cnt;
`ifdef UART_CMD_ACK_EN
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;
`endif

  uart_cmd_led_ctrl #(
    .N_CH(N_CH), .PWM_BITS(PWM_BITS), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .overlay(overlay), .led(led), .hit_mask(hit_mask), .brightness(brightness),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_cnt(err_cnt)
`ifdef UART_CMD_ACK_EN
    , .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes collected for the frame in progress plus visible state
  logic [7:0] m_buf[$];
  int         m_mask;
  int         m_bright;
  int         m_err;
  int         m_ok_p;
  int         m_err_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_buf.delete();
    m_mask = 0; m_bright = 15; m_err = 0; m_ok_p = 0; m_err_p = 0;
  endtask

  task automatic model_error();
    m_err_p = 1;
    if (m_err < 255) m_err++;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int cmd, arg, idx;
    m_ok_p = 0; m_err_p = 0;
    if (m_buf.size() == 0) begin
      if (b == 8'h41 || b == 8'h42 || b == 8'h43) m_buf.push_back(b);
      else model_error();
    end else if (m_buf.size() == 1) begin
      m_buf.push_back(b);
    end else begin
      cmd = int'(m_buf[0]);
      arg = int'(m_buf[1]);
      m_buf.delete();
      if (int'(b) != cmd) model_error();
      else if (cmd == 65) begin
        idx = arg - 65;
        if (arg == 96) begin m_mask = 0; m_ok_p = 1; end
        else if (idx >= 0 && idx < int'(N_CH)) begin m_mask = m_mask | (1 << idx); m_ok_p = 1; end
        else model_error();
      end else if (cmd == 66) begin
        m_bright = arg % 16; m_ok_p = 1;
      end else begin
        m_mask = (m_mask & ~255) | arg; m_ok_p = 1;
      end
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ok"},     32'(frame_ok),   32'(m_ok_p));
    chk({tag, ".err"},    32'(frame_err),  32'(m_err_p));
    chk({tag, ".mask"},   32'(hit_mask),   32'(m_mask));
    chk({tag, ".bright"}, 32'(brightness), 32'(m_bright));
    chk({tag, ".errcnt"}, 32'(err_cnt),    32'(m_err));
  endtask

  // Drive one byte for one cycle; results are visible at the following falling edge
  task automatic send_byte(input logic [7:0] b, input string tag);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    model_byte(b);
    check_state(tag);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input string tag);
    send_byte(c, tag);
    send_byte(a, tag);
    send_byte(c, tag);
  endtask

  // Over one full PWM period led must equal the pattern for exactly brightness cycles and be 0 otherwise
  task automatic pwm_window(input string tag);
    int on_cnt, odd_cnt;
    logic [N_CH-1:0] pat;
    pat = N_CH'(m_mask) | overlay;
    repeat (2) @(negedge clk);
    on_cnt = 0; odd_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (led != '0) on_cnt++;
      if (led != '0 && led != pat) odd_cnt++;
      @(negedge clk);
    end
    chk({tag, ".on"},  32'(on_cnt),  (pat != '0) ? 32'(m_bright) : 32'd0);
    chk({tag, ".odd"}, 32'(odd_cnt), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".led"},    32'(led),        32'd0);
    chk({tag, ".mask"},   32'(hit_mask),   32'd0);
    chk({tag, ".bright"}, 32'(brightness), 32'd15);
    chk({tag, ".ok"},     32'(frame_ok),   32'd0);
    chk({tag, ".err"},    32'(frame_err),  32'd0);
    chk({tag, ".errcnt"}, 32'(err_cnt),    32'd0);
`ifdef UART_CMD_ACK_EN
    chk({tag, ".txv"},    32'(tx_valid),   32'd0);
    chk({tag, ".txd"},    32'(tx_data),    32'd0);
`endif
  endtask

  initial begin
    int seen_err;
    logic [7:0] c, a, t;
    int r;

    reset_n  = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    overlay  = '0;
`ifdef UART_CMD_ACK_EN
    tx_ready = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single hit on channel C, pulse lasts one cycle, led[2] follows the PWM
    send_frame(8'h41, 8'h43, "hitC");
    chk("hitC.mask_val", 32'(hit_mask), 32'h04);
    @(negedge clk);
    m_ok_p = 0; m_err_p = 0;
    check_state("hitC.after");
    pwm_window("hitC.pwm");

    // More hits, clear, out-of-range channel
    send_frame(8'h41, 8'h42, "hitB");
    send_frame(8'h41, 8'h45, "hitE");
    chk("hitBE.mask_val", 32'(hit_mask), 32'h16);
    send_frame(8'h41, 8'h60, "clear");
    send_frame(8'h41, 8'h5A, "hitZ");
    chk("hitZ.errcnt_val", 32'(err_cnt), 32'd1);

    // Brightness extremes with full overlay
    overlay = '1;
    send_frame(8'h42, 8'h00, "dark");
    pwm_window("dark.pwm");
    send_frame(8'h42, 8'h0F, "bright");
    pwm_window("bright.pwm");
    overlay = '0;

    // Timeout after TMO idle cycles
    send_byte(8'h43, "tmo.cmd");
    seen_err = 0;
    repeat (TMO) begin
      @(negedge clk);
      if (frame_err) seen_err = 1;
    end
    chk("tmo.early", 32'(seen_err), 32'd0);
    @(negedge clk);
    m_buf.delete();
    model_error();
    m_ok_p = 0;
    check_state("tmo.fire");

    // Byte arriving on the expiry cycle is processed, frame then completes
    @(negedge clk);
    send_byte(8'h43, "exp.cmd");
    repeat (TMO) @(negedge clk);
    send_byte(8'h05, "exp.arg");
    send_byte(8'h43, "exp.end");

    // Randomized frames against the model
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      c = (r < 3) ? 8'h41 : (r < 6) ? 8'h42 : (r < 8) ? 8'h43 : 8'($urandom);
      r = int'($urandom_range(0, 3));
      if (c == 8'h41 && r == 0) a = 8'h60;
      else if (c == 8'h41 && r < 3) a = 8'h41 + 8'($urandom_range(0, 11));
      else a = 8'($urandom);
      t = ($urandom_range(0, 99) < 85) ? c : 8'($urandom);
      overlay = N_CH'($urandom);
      send_byte(c, "rnd.b0");
      send_byte(a, "rnd.b1");
      send_byte(t, "rnd.b2");
      if (n % 30 == 0) pwm_window("rnd.pwm");
    end
    // Drain any partial frame left over by the random stream
    repeat (TMO + 4) @(negedge clk);
    if (m_buf.size() != 0) begin
      m_buf.delete();
      model_error();
    end
    m_ok_p = 0; m_err_p = 0;
    check_state("rnd.drain");
    overlay = '0;

    // Error counter saturation
    for (int n = 0; n < 256; n++) send_byte(8'h00, "sat");
    chk("sat.errcnt_val", 32'(err_cnt), 32'd255);

    // Reset in the middle of a frame
    send_byte(8'h41, "abort.cmd");
    send_byte(8'h41, "abort.arg");
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("abort");
    reset_n = 1'b1;
    @(negedge clk);
    check_state("abort.idle");
    send_frame(8'h42, 8'h03, "post");

`ifdef UART_CMD_ACK_EN
    // Ack held while tx_ready is low; second ack and an error ack are dropped
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_frame(8'h42, 8'h07, "ack1");
    chk("ack1.txv", 32'(tx_valid), 32'd1);
    chk("ack1.txd", 32'(tx_data), 32'h4B);
    send_frame(8'h42, 8'h09, "ack2");
    send_byte(8'h00, "ack2.bad");
    chk("ack2.txv", 32'(tx_valid), 32'd1);
    chk("ack2.txd", 32'(tx_data), 32'h4B);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    chk("ack.drain", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("ack.idle", 32'(tx_valid), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
